// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit: one-cycle ADD/SUB/AND/OR/SLT, iterative MUL and DIVU,
// with a valid/ready request port and a held result until the consumer accepts it.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | out_valid high, result held until out_ready
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALU_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_ILL} op_t;

    state_t           state, state_nxt;
    op_t              op_dec;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   acc;

    logic             accept, last_iter, go_mul, go_div;
    logic [WIDTH-1:0] fast_res;
    logic             fast_err;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_sh, rem_nxt;
    logic             div_ge;
    logic [WIDTH-1:0] quo_nxt;

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == '0);
    assign go_mul    = (op_dec == OP_MUL);
    assign go_div    = (op_dec == OP_DIV) && (b != '0);

    always_comb begin
        op_dec = OP_ILL;
        case (ALU_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (func)
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b101010: op_dec = OP_SLT;
                    6'b011000: op_dec = OP_MUL;
                    6'b011010: op_dec = OP_DIV;
                    default:   op_dec = OP_ILL;
                endcase
            end
            default: op_dec = OP_ILL;
        endcase
    end

    // Single-cycle results; DIV only lands here when b is zero.
    always_comb begin
        fast_res = '0;
        fast_err = 1'b0;
        case (op_dec)
            OP_ADD: fast_res = a + b;
            OP_SUB: fast_res = a - b;
            OP_AND: fast_res = a & b;
            OP_OR:  fast_res = a | b;
            OP_SLT: fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIV: begin
                fast_res = '1;
                fast_err = 1'b1;
            end
            OP_ILL: fast_err = 1'b1;
            default: fast_res = '0;
        endcase
    end

    // opa/opb double as multiplicand/multiplier in MUL and dividend-quotient/divisor in DIV.
    assign mul_sum = acc[WIDTH-1:0] + (opb[0] ? opa : '0);
    assign rem_sh  = {acc[WIDTH-1:0], opa[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, opb});
    assign rem_nxt = div_ge ? (rem_sh - {1'b0, opb}) : rem_sh;
    assign quo_nxt = {opa[WIDTH-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (go_mul)      state_nxt = S_MUL;
                    else if (go_div) state_nxt = S_DIV;
                    else             state_nxt = S_DONE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opa <= a;
                        opb <= b;
                        acc <= '0;
                        cnt <= CW'(WIDTH - 1);
                        if (!(go_mul || go_div)) begin
                            result <= fast_res;
                            zero   <= (fast_res == '0);
                            err    <= fast_err;
                        end
                    end
                end
                S_MUL: begin
                    acc <= {1'b0, mul_sum};
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    if (last_iter) begin
                        result <= mul_sum;
                        zero   <= (mul_sum == '0);
                        err    <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    acc <= rem_nxt;
                    opa <= quo_nxt;
                    if (last_iter) begin
                        result <= quo_nxt;
                        zero   <= (quo_nxt == '0);
                        err    <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit at WIDTH=8: expected results are queued when a
// request is issued and popped when the unit presents out_valid.
module tb_alu_exec_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   ALU_op;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;

    int n_checks = 0;
    int n_bad    = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         e;
        int           lat;
    } exp_t;

    exp_t sb[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(ALU_op), .func(func), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [1:0] op, logic [5:0] f, logic [W-1:0] x, logic [W-1:0] y);
        exp_t r;
        logic [15:0] p;
        r.res = '0; r.e = 1'b0; r.lat = 1;
        case (op)
            2'b00: r.res = x + y;
            2'b01: r.res = x - y;
            2'b10: begin
                case (f)
                    6'b100000: r.res = x + y;
                    6'b100010: r.res = x - y;
                    6'b100100: r.res = x & y;
                    6'b100101: r.res = x | y;
                    6'b101010: r.res = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
                    6'b011000: begin p = x * y; r.res = p[7:0]; r.lat = W + 1; end
                    6'b011010: begin
                        if (y == 0) begin r.res = 8'hFF; r.e = 1'b1; end
                        else begin r.res = x / y; r.lat = W + 1; end
                    end
                    default: r.e = 1'b1;
                endcase
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 0);
        return r;
    endfunction

    task automatic issue(logic [1:0] op, logic [5:0] f, logic [W-1:0] x, logic [W-1:0] y);
        sb.push_back(model(op, f, x, y));
        ALU_op = op; func = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 1; rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALU_op = 2'b00; func = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result got=%h want=00", result); end
        n_checks++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got=%b want=0", zero); end
        n_checks++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    task automatic test_single_cycle();
        logic [1:0]   ops[10] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [5:0]   fns[10] = '{6'b100010, 6'b101010, 6'b101010, 6'b111111, 6'b000000,
                                  6'b100100, 6'b100101, 6'b100000, 6'b100000, 6'b111000};
        logic [W-1:0] xs[10]  = '{8'd5, 8'hFE, 8'h01, 8'd3, 8'd2, 8'hF0, 8'hA0, 8'hFF, 8'd9, 8'd1};
        logic [W-1:0] ys[10]  = '{8'd5, 8'h01, 8'hFE, 8'd4, 8'd5, 8'h3C, 8'h05, 8'h02, 8'd9, 8'd1};
        exp_t e;
        int lat;
        bit rs;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], fns[i], xs[i], ys[i]);
            wait_out(lat, rs);
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res || zero !== e.z || err !== e.e || lat != e.lat) begin
                n_bad++;
                $display("FAIL single_%0d got res=%h z=%b e=%b lat=%0d want res=%h z=%b e=%b lat=%0d",
                         i, result, zero, err, lat, e.res, e.z, e.e, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_mul();
        exp_t e;
        int lat;
        bit rs;
        issue(2'b10, 6'b011000, 8'd13, 8'd11);
        // Operand changes and request attempts during the iteration must be ignored.
        a = 8'hFF; b = 8'hFF; ALU_op = 2'b00; in_valid = 1'b1;
        wait_out(lat, rs);
        in_valid = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res || zero !== e.z || err !== e.e || lat != e.lat) begin
            n_bad++;
            $display("FAIL mul_13x11 got res=%h z=%b e=%b lat=%0d want res=%h z=%b e=%b lat=%0d",
                     result, zero, err, lat, e.res, e.z, e.e, e.lat);
        end
        n_checks++; if (rs !== 1'b0) begin n_bad++; $display("FAIL mul_in_ready_low got=%b want=0", rs); end
        release_out();
    endtask

    task automatic test_div();
        logic [W-1:0] xs[3] = '{8'd200, 8'd200, 8'd3};
        logic [W-1:0] ys[3] = '{8'd7,   8'd0,   8'd9};
        exp_t e;
        int lat;
        bit rs;
        for (int i = 0; i < 3; i++) begin
            issue(2'b10, 6'b011010, xs[i], ys[i]);
            wait_out(lat, rs);
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res || zero !== e.z || err !== e.e || lat != e.lat) begin
                n_bad++;
                $display("FAIL div_%0d got res=%h z=%b e=%b lat=%0d want res=%h z=%b e=%b lat=%0d",
                         i, result, zero, err, lat, e.res, e.z, e.e, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        bit rs;
        issue(2'b10, 6'b100101, 8'h30, 8'h05);
        wait_out(lat, rs);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            ALU_op = 2'b00; a = 8'd1; b = 8'd1; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || result !== e.res || err !== e.e) begin
                n_bad++;
                $display("FAIL hold_%0d got v=%b res=%h e=%b want v=1 res=%h e=%b", i, out_valid, result, err, e.res, e.e);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_no_extra got v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        bit rs;
        bit seen;
        issue(2'b10, 6'b011000, 8'd13, 8'd11);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_quiet got v_seen=%b want 0", seen); end
        issue(2'b00, 6'b000000, 8'd3, 8'd4);
        wait_out(lat, rs);
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res || zero !== e.z || err !== e.e || lat != e.lat) begin
            n_bad++;
            $display("FAIL post_reset_add got res=%h z=%b e=%b lat=%0d want res=%h z=%b e=%b lat=%0d",
                     result, zero, err, lat, e.res, e.z, e.e, e.lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [5:0] fl[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'b011010};
        exp_t e;
        int lat;
        bit rs;
        for (int i = 0; i < 12; i++) begin
            issue(2'b10, fl[$urandom_range(0, 6)], W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_out(lat, rs);
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res || zero !== e.z || err !== e.e || lat != e.lat) begin
                n_bad++;
                $display("FAIL rand_%0d got res=%h z=%b e=%b lat=%0d want res=%h z=%b e=%b lat=%0d",
                         i, result, zero, err, lat, e.res, e.z, e.e, e.lat);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 ALU_op  input  2  main-decoder class: 00 add, 01 sub, 10 R-type (use func), 11 illegal.
REQ-007 func  input  6  R-type function field.
REQ-008 a, b  input  WIDTH each  operands (a = rs, b = rt/immediate).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result == 0.
REQ-013 err  output  1  illegal op or divide-by-zero on this result.

Function
REQ-014 Request accepted only on cycle where in_valid && in_ready; ALU_op, func, a, b captured into internal registers on that cycle.
REQ-015 Decode (ALU_op=10): func 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed), 011000 MUL (low WIDTH bits, unsigned), 011010 DIVU (unsigned quotient); any other func is illegal.
REQ-016 ALU_op 00 -> ADD, 01 -> SUB, 11 -> illegal, func ignored for 00/01/11.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-018 SLT result = {WIDTH-1 zeros, (signed a < signed b)}.
REQ-019 States: IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-020 IDLE: on accept of ADD/SUB/AND/OR/SLT/illegal -> DONE next cycle (latency 1: out_valid high the cycle after accept).
REQ-021 IDLE: on accept of MUL -> MUL; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (out_valid WIDTH+1 cycles after accept).
REQ-022 IDLE: on accept of DIVU with b != 0 -> DIV; restoring division, one quotient bit per cycle, exactly WIDTH cycles, then DONE (latency WIDTH+1).
REQ-023 DIVU with b == 0 -> DONE next cycle, result all ones, err=1.
REQ-024 Illegal op -> result 0, err=1, zero=1.
REQ-025 Iteration counter width $clog2(WIDTH)+1; counts WIDTH-1 down to 0, leaves MUL/DIV when counter is 0.
REQ-026 DONE: out_valid=1, result/zero/err stable until out_ready=1; on out_valid && out_ready -> IDLE next cycle.
REQ-027 No request overlap: new request accepted earliest the cycle after DONE handshake.
REQ-028 in_valid while not in_ready has no effect; operand changes during MUL/DIV do not affect result.
REQ-029 out_valid=0 in IDLE, MUL, DIV; result/zero/err are don't-care outside DONE but held at last value (no X).

Reset
REQ-030 rst=1 at clock edge -> state IDLE, counter 0, out_valid=0, in_ready=1 next cycle, result=0, zero=0, err=0.
REQ-031 rst dominates all other inputs, including mid-MUL/DIV and in DONE; pending result discarded, no out_valid emitted.

Verification (WIDTH=8 unless noted)
REQ-032 ALU_op=10 func=100010 a=5 b=5 -> out_valid 1 cycle after accept, result=0x00, zero=1, err=0.
REQ-033 ALU_op=10 func=101010 a=0xFE(-2) b=0x01 -> result=0x01; a=0x01 b=0xFE -> result=0x00.
REQ-034 ALU_op=10 func=011000 a=13 b=11 -> out_valid exactly 9 cycles after accept, result=0x8F (143); in_ready=0 throughout.
REQ-035 ALU_op=10 func=011010 a=200 b=7 -> result=28 after 9 cycles; b=0 -> result=0xFF, err=1 after 1 cycle.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and result stable 5 cycles; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-037 rst asserted 4 cycles into MUL -> next cycle in_ready=1, out_valid=0; following ADD a=3 b=4 -> result=7 normally.
